mips_mc_ctrl: RTL
=================

Name: mips_mc_ctrl

Overview:
- Next-generation multicycle MIPS control unit for the 8-bit-family cores; drives the same datapath control bundle as the current controller.
- Generalises instruction fetch to a parametrised number of beats.
- Adds a memory-ready wait-state handshake, plus ADDI, BNE and illegal-opcode trapping.
- Sits between the instruction register fields (op/funct), the datapath and the external memory.

Parameters:
- FETCH_BEATS, 4, number of memory beats per 32-bit instruction fetch; legal values 1, 2, 4. Sets irwrite width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  0=PC, 1=A register
- alusrcb  out  2  00=B, 01=one, 10=imm, 11=imm<<2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- memtoreg  out  1  write-back source select
- iord  out  1  address select, 0=PC, 1=ALUOut
- pcen  out  1  PC register enable
- pcsrc  out  2  00=ALU, 01=ALUOut, 10=jump
- regwrite  out  1  register file write
- regdst  out  1  0=rt, 1=rd
- irwrite  out  FETCH_BEATS  one-hot IR beat write enable
- illegal_op  out  1  one-cycle pulse on undefined opcode
- instret  out  32  retired-instruction count (optional feature)
- stallcnt  out  32  wait-state cycle count (optional feature)

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset:
  - State becomes FETCH with beat counter 0; counters clear.
  - While reset is high, memread, memwrite, regwrite, pcen, irwrite and illegal_op are all forced to 0.
- States: FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, ADDIEX, ADDIWR, BEQEX, BNEEX, JEX, ILLEGAL.
- Outputs are Moore-decoded from state and beat, except that handshake gating uses mem_ready combinationally.
- Defaults in every state: all strobes 0, selects 00, aluop add.
- FETCH:
  - memread=1, alusrcb=01.
  - irwrite=onehot(beat) & {mem_ready}; pcen=mem_ready.
  - On mem_ready, beat increments; after the last beat (FETCH_BEATS-1), go to DECODE and reset beat to 0.
  - With mem_ready=0, hold state and beat.
- DECODE:
  - alusrcb=11.
  - Next state by op: 100000 LB or 101000 SB -> MEMADR; 000000 R-type -> RTYPEEX; 001000 ADDI -> ADDIEX; 000100 BEQ -> BEQEX; 000101 BNE -> BNEEX; 000010 J -> JEX; any other op -> ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10; LB -> LBRD, SB -> SBWR.
- LBRD: memread=1, iord=1; on mem_ready go to LBWR, otherwise stay.
- LBWR: regwrite=1, memtoreg=1; -> FETCH.
- SBWR: memwrite=1, iord=1, held until mem_ready; then -> FETCH.
- RTYPEEX: alusrca=1, alucontrol from funct.
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 101.
  - Next state RTYPEWR.
- RTYPEWR: regdst=1, regwrite=1; -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add; -> ADDIWR.
- ADDIWR: regdst=0, regwrite=1; -> FETCH.
- BEQEX: alusrca=1, sub, pcsrc=01, pcen=zero; -> FETCH.
- BNEEX: as BEQEX but pcen=~zero.
- JEX: pcsrc=10, pcen=1; -> FETCH.
- ILLEGAL: illegal_op=1 for one cycle, no state writes; -> FETCH.
- Latency with mem_ready held at 1: R-type, ADDI and SB take FETCH_BEATS+3 cycles; LB takes FETCH_BEATS+4; BEQ, BNE and J take FETCH_BEATS+2.
- Each wait state adds exactly one cycle.
- Reset asserted mid-instruction aborts it; no strobe fires in the reset cycle.

Optional Feature:
- Macro MIPS_MC_CTRL_PERF_EN.
- Defined:
  - instret increments on each transition into FETCH from an executing state; ILLEGAL does not count.
  - stallcnt increments on each cycle spent in FETCH, LBRD or SBWR with mem_ready=0.
  - Both wrap at 2^32 and clear on reset.
- Undefined: instret and stallcnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset held for 2 cycles, then mem_ready=1 and op=000000, funct=100000:
  - irwrite sequence 0001, 0010, 0100, 1000, pcen=1 on each beat.
  - DECODE, then RTYPEEX with alucontrol=010, then RTYPEWR with regwrite=1, regdst=1; 7 cycles total.
- LB with mem_ready low for 3 cycles in LBRD:
  - memread=1 and iord=1 held for 4 cycles.
  - LBWR regwrite=1 only after mem_ready; stallcnt=3 when MIPS_MC_CTRL_PERF_EN is defined.
- BNE with zero=0 -> pcen=1, pcsrc=01 in BNEEX.
- BEQ with zero=0 -> pcen=0; BEQ with zero=1 -> pcen=1.
- op=111111 -> illegal_op=1 for exactly 1 cycle, regwrite and memwrite stay 0, next state FETCH beat 0; instret unchanged.
- FETCH_BEATS=2 with ADDI:
  - irwrite 01 then 10.
  - ADDIEX alusrcb=10, ADDIWR regwrite=1 with regdst=0; 5 cycles total.
  - Reset asserted in ADDIEX -> no regwrite; FETCH beat 0 on the next cycle.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit with multi-beat fetch, memory wait states and illegal-op trap.
// Optional performance counters are built when MIPS_MC_CTRL_PERF_EN is defined.
module mips_mc_ctrl #(
  parameter int unsigned FETCH_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic [5:0]             funct,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   memread,
  output logic                   memwrite,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic [2:0]             alucontrol,
  output logic                   memtoreg,
  output logic                   iord,
  output logic                   pcen,
  output logic [1:0]             pcsrc,
  output logic                   regwrite,
  output logic                   regdst,
  output logic [FETCH_BEATS-1:0] irwrite,
  output logic                   illegal_op,
  output logic [31:0]            instret,
  output logic [31:0]            stallcnt
);

  localparam int unsigned BEAT_W = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_LBRD    = 4'd3;
  localparam logic [3:0] S_LBWR    = 4'd4;
  localparam logic [3:0] S_SBWR    = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWR = 4'd7;
  localparam logic [3:0] S_ADDIEX  = 4'd8;
  localparam logic [3:0] S_ADDIWR  = 4'd9;
  localparam logic [3:0] S_BEQEX   = 4'd10;
  localparam logic [3:0] S_BNEEX   = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;
  localparam logic [3:0] S_ILLEGAL = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_UNK = 3'b101;

  logic [3:0]             state, state_next;
  logic [BEAT_W-1:0]      beat, beat_next;
  logic [FETCH_BEATS-1:0] beat_onehot;

  logic                   memread_c, memwrite_c, pcen_c, regwrite_c, illegal_op_c;
  logic [FETCH_BEATS-1:0] irwrite_c;

  assign beat_onehot = FETCH_BEATS'(1) << beat;

  // State and fetch-beat registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Next-state and Moore control decode; mem_ready only gates the handshake strobes
  always_comb begin
    state_next   = state;
    beat_next    = beat;
    memread_c    = 1'b0;
    memwrite_c   = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    alucontrol   = ALU_ADD;
    memtoreg     = 1'b0;
    iord         = 1'b0;
    pcen_c       = 1'b0;
    pcsrc        = 2'b00;
    regwrite_c   = 1'b0;
    regdst       = 1'b0;
    irwrite_c    = '0;
    illegal_op_c = 1'b0;

    case (state)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb   = 2'b01;
        if (mem_ready) begin
          irwrite_c = beat_onehot;
          pcen_c    = 1'b1;
          if (beat == LAST_BEAT) begin
            state_next = S_DECODE;
            beat_next  = '0;
          end else begin
            beat_next = beat + BEAT_W'(1);
          end
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LB, OP_SB: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_BNE:       state_next = S_BNEEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_SB) ? S_SBWR : S_LBRD;
      end
      S_LBRD: begin
        memread_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_next = S_LBWR;
      end
      S_LBWR: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
        state_next = S_FETCH;
      end
      S_SBWR: begin
        memwrite_c = 1'b1;
        iord       = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_UNK;
        endcase
        state_next = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADDIWR;
      end
      S_ADDIWR: begin
        regwrite_c = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen_c     = (state == S_BEQEX) ? zero : ~zero;
        state_next = S_FETCH;
      end
      S_JEX: begin
        pcsrc      = 2'b10;
        pcen_c     = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_op_c = 1'b1;
        state_next   = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
        beat_next  = '0;
      end
    endcase
  end

  // No state-changing strobe may fire while reset is held
  assign memread    = memread_c    & ~reset;
  assign memwrite   = memwrite_c   & ~reset;
  assign pcen       = pcen_c       & ~reset;
  assign regwrite   = regwrite_c   & ~reset;
  assign illegal_op = illegal_op_c & ~reset;
  assign irwrite    = irwrite_c    & {FETCH_BEATS{~reset}};

`ifdef MIPS_MC_CTRL_PERF_EN
  logic [31:0] instret_q, stallcnt_q;
  logic        retire_c, stall_c;

  // A retirement is any return to FETCH from an executing state; trapped ops do not count
  assign retire_c = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_ILLEGAL);
  assign stall_c  = !mem_ready && ((state == S_FETCH) || (state == S_LBRD) || (state == S_SBWR));

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q  <= '0;
      stallcnt_q <= '0;
    end else begin
      if (retire_c) instret_q  <= instret_q + 32'd1;
      if (stall_c)  stallcnt_q <= stallcnt_q + 32'd1;
    end
  end

  assign instret  = instret_q;
  assign stallcnt = stallcnt_q;
`else
  assign instret  = '0;
  assign stallcnt = '0;
`endif

endmodule
